refresh_counter_allocator: RTL and testbench

// Allocates a pool of NUM_COUNTERS per-bank refresh-cycle-time (tRFCpb) counters to incoming
// per-bank refresh requests. Sits between the refresh scheduler and the counter instances.

---
 rtl/refresh_counter_allocator.sv | 107 ++++++++++
 tb/tb_refresh_counter_allocator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_counter_allocator.sv
// Hands out per-bank tRFCpb counter slots to refresh requests, blocks a second refresh
// to a bank already in flight, and retires slots on counter completion.
module refresh_counter_allocator #(
   parameter int NUM_COUNTERS    = 4,
   parameter int NUM_BANKS       = 8,
   parameter int BANK_ADDR_WIDTH = 3,
   parameter int TRFC_PB_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   input  logic [BANK_ADDR_WIDTH-1:0] req_bank,
   output logic                       req_ready,
   input  logic [TRFC_PB_WIDTH-1:0]   trfc_pb,
   output logic [NUM_COUNTERS-1:0]    cnt_start,
   output logic [BANK_ADDR_WIDTH-1:0] cnt_bank,
   output logic [TRFC_PB_WIDTH-1:0]   cnt_trfc,
   input  logic [NUM_COUNTERS-1:0]    cnt_done,
   output logic [NUM_COUNTERS-1:0]    slot_busy,
   output logic [NUM_BANKS-1:0]       bank_busy,
   output logic [NUM_BANKS-1:0]       bank_done,
   output logic                       err_spurious
);

   logic [BANK_ADDR_WIDTH-1:0] slot_bank [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0]    sel_onehot;
   logic                       any_free;
   logic [NUM_BANKS-1:0]       bank_match;
   logic [NUM_BANKS-1:0]       bank_set;
   logic [NUM_BANKS-1:0]       bank_clear;
   logic [NUM_COUNTERS-1:0]    done_valid;
   logic                       spurious;
   logic                       accept;

   // Lowest-index free slot wins the allocation.
   always_comb begin
      sel_onehot = '0;
      any_free   = 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (!slot_busy[i] && !any_free) begin
            sel_onehot[i] = 1'b1;
            any_free      = 1'b1;
         end
      end
   end

   // An out-of-range bank address decodes to no bank at all, so it can never be ready.
   always_comb begin
      bank_match = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_match[b] = (req_bank == BANK_ADDR_WIDTH'(b));
      end
   end

   // Ready is held low during reset so nothing is accepted while every output is forced to 0.
   assign req_ready  = rst_n && any_free && (|bank_match) && !(|(bank_match & bank_busy));
   assign accept     = req_valid && req_ready;
   assign bank_set   = accept ? bank_match : '0;
   assign done_valid = cnt_done & slot_busy;
   assign spurious   = |(cnt_done & ~slot_busy);

   always_comb begin
      bank_clear = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (done_valid[i] && (slot_bank[i] == BANK_ADDR_WIDTH'(b))) begin
               bank_clear[b] = 1'b1;
            end
         end
      end
   end

   // Retire and allocate can share an edge: ready came from pre-edge state, so the
   // newly set slot/bank is never one being cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_busy    <= '0;
         bank_busy    <= '0;
         bank_done    <= '0;
         cnt_start    <= '0;
         cnt_bank     <= '0;
         cnt_trfc     <= '0;
         err_spurious <= 1'b0;
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            slot_bank[i] <= '0;
         end
      end else begin
         slot_busy <= (slot_busy & ~done_valid) | (accept ? sel_onehot : '0);
         bank_busy <= (bank_busy & ~bank_clear) | bank_set;
         bank_done <= bank_clear;
         cnt_start <= accept ? sel_onehot : '0;
         if (spurious) begin
            err_spurious <= 1'b1;
         end
         if (accept) begin
            cnt_bank <= req_bank;
            cnt_trfc <= trfc_pb;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
               if (sel_onehot[i]) begin
                  slot_bank[i] <= req_bank;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_refresh_counter_allocator.sv
// Directed bench for refresh_counter_allocator: a behavioural slot/bank model pushes the
// expected post-edge state into a scoreboard queue, popped and compared after each edge.
module tb_refresh_counter_allocator;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [2:0] req_bank;
   logic       req_ready;
   logic [7:0] trfc_pb;
   logic [3:0] cnt_start;
   logic [2:0] cnt_bank;
   logic [7:0] cnt_trfc;
   logic [3:0] cnt_done;
   logic [3:0] slot_busy;
   logic [7:0] bank_busy;
   logic [7:0] bank_done;
   logic       err_spurious;

   typedef struct packed {
      logic [3:0] start;
      logic [2:0] cbank;
      logic [7:0] ctrfc;
      logic [7:0] bdone;
      logic [7:0] bbusy;
      logic [3:0] sbusy;
      logic       err;
   } exp_t;

   exp_t       sb [$];
   int         checks;
   int         errors;
   logic [3:0] m_slot_busy;
   logic [2:0] m_slot_bank [4];
   logic [7:0] m_bank_busy;
   logic [2:0] m_cnt_bank;
   logic [7:0] m_cnt_trfc;
   logic       m_err;

   refresh_counter_allocator #(
      .NUM_COUNTERS(4),
      .NUM_BANKS(8),
      .BANK_ADDR_WIDTH(3),
      .TRFC_PB_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_bank(req_bank),
      .req_ready(req_ready),
      .trfc_pb(trfc_pb),
      .cnt_start(cnt_start),
      .cnt_bank(cnt_bank),
      .cnt_trfc(cnt_trfc),
      .cnt_done(cnt_done),
      .slot_busy(slot_busy),
      .bank_busy(bank_busy),
      .bank_done(bank_done),
      .err_spurious(err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_slot_busy = '0;
      m_bank_busy = '0;
      m_cnt_bank  = '0;
      m_cnt_trfc  = '0;
      m_err       = 1'b0;
      for (int i = 0; i < 4; i++) m_slot_bank[i] = '0;
      sb.delete();
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      checkOutput({tag, "_cnt_start"}, 32'(cnt_start), 32'd0);
      checkOutput({tag, "_cnt_bank"}, 32'(cnt_bank), 32'd0);
      checkOutput({tag, "_cnt_trfc"}, 32'(cnt_trfc), 32'd0);
      checkOutput({tag, "_slot_busy"}, 32'(slot_busy), 32'd0);
      checkOutput({tag, "_bank_busy"}, 32'(bank_busy), 32'd0);
      checkOutput({tag, "_bank_done"}, 32'(bank_done), 32'd0);
      checkOutput({tag, "_err"}, 32'(err_spurious), 32'd0);
   endtask

   // Called at posedge+1; leaves the bench at the next posedge+1.
   task automatic applyStimulus(input logic v, input logic [2:0] b, input logic [7:0] t, input logic [3:0] d);
      logic       exp_ready;
      logic       acc;
      int         sel;
      logic [3:0] start;
      logic [7:0] bdone;
      exp_t       e;
      exp_t       got;
      req_valid = v;
      req_bank  = b;
      trfc_pb   = t;
      cnt_done  = d;
      @(negedge clk);
      exp_ready = (m_slot_busy != 4'hF) && !m_bank_busy[b];
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      acc = v && exp_ready;
      sel = -1;
      for (int i = 3; i >= 0; i--) if (!m_slot_busy[i]) sel = i;
      bdone = '0;
      start = '0;
      for (int i = 0; i < 4; i++) begin
         if (d[i] && m_slot_busy[i]) begin
            bdone[m_slot_bank[i]]       = 1'b1;
            m_bank_busy[m_slot_bank[i]] = 1'b0;
            m_slot_busy[i]              = 1'b0;
         end else if (d[i]) begin
            m_err = 1'b1;
         end
      end
      if (acc) begin
         m_slot_busy[sel] = 1'b1;
         m_slot_bank[sel] = b;
         m_bank_busy[b]   = 1'b1;
         m_cnt_bank       = b;
         m_cnt_trfc       = t;
         start[sel]       = 1'b1;
      end
      e = '{start: start, cbank: m_cnt_bank, ctrfc: m_cnt_trfc, bdone: bdone,
            bbusy: m_bank_busy, sbusy: m_slot_busy, err: m_err};
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cnt_done  = '0;
      got = sb.pop_front();
      checkOutput("cnt_start", 32'(cnt_start), 32'(got.start));
      checkOutput("cnt_bank", 32'(cnt_bank), 32'(got.cbank));
      checkOutput("cnt_trfc", 32'(cnt_trfc), 32'(got.ctrfc));
      checkOutput("bank_done", 32'(bank_done), 32'(got.bdone));
      checkOutput("bank_busy", 32'(bank_busy), 32'(got.bbusy));
      checkOutput("slot_busy", 32'(slot_busy), 32'(got.sbusy));
      checkOutput("err_spurious", 32'(err_spurious), 32'(got.err));
   endtask

   task automatic doReset(input string tag);
      req_valid = 1'b0;
      cnt_done  = '0;
      req_bank  = '0;
      rst_n     = 1'b0;
      #2;
      checkReset(tag);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_bank  = '0;
      trfc_pb   = '0;
      cnt_done  = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkReset("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] reset and restart");
      applyStimulus(1'b1, 3'd0, 8'd9, 4'b0000);
      checkOutput("t1_start", 32'(cnt_start), 32'h1);
      applyStimulus(1'b1, 3'd6, 8'd12, 4'b0000);
      doReset("midrun");

      $display("[TB] single refresh");
      applyStimulus(1'b1, 3'd3, 8'd5, 4'b0000);
      checkOutput("t2_start", 32'(cnt_start), 32'h1);
      checkOutput("t2_bank", 32'(cnt_bank), 32'd3);
      checkOutput("t2_trfc", 32'(cnt_trfc), 32'd5);
      checkOutput("t2_bank_busy", 32'(bank_busy), 32'h08);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b0000);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b0001);
      checkOutput("t2_bank_done", 32'(bank_done), 32'h08);
      checkOutput("t2_bank_clear", 32'(bank_busy), 32'h00);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b0000);
      checkOutput("t2_done_pulse", 32'(bank_done), 32'h00);

      $display("[TB] full pool");
      for (int b = 0; b < 4; b++) begin
         applyStimulus(1'b1, 3'(b), (b == 2) ? 8'd0 : 8'($urandom_range(1, 255)), 4'b0000);
         checkOutput("t3_start", 32'(cnt_start), 32'(4'b0001 << b));
      end
      applyStimulus(1'b1, 3'd4, 8'd20, 4'b0000);
      checkOutput("t3_full_start", 32'(cnt_start), 32'h0);
      applyStimulus(1'b1, 3'd4, 8'd20, 4'b0001);
      applyStimulus(1'b1, 3'd4, 8'd20, 4'b0000);
      checkOutput("t3_reuse_start", 32'(cnt_start), 32'h1);
      checkOutput("t3_reuse_bank", 32'(cnt_bank), 32'd4);

      $display("[TB] duplicate bank");
      applyStimulus(1'b1, 3'd2, 8'd7, 4'b0000);
      checkOutput("t4_dup_start", 32'(cnt_start), 32'h0);
      applyStimulus(1'b1, 3'd2, 8'd7, 4'b0100);
      checkOutput("t4_bank_done", 32'(bank_done), 32'h04);
      applyStimulus(1'b1, 3'd2, 8'd7, 4'b0000);
      checkOutput("t4_start", 32'(cnt_start), 32'h4);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b1111);
      checkOutput("t4_all_done", 32'(bank_done), 32'h1E);

      $display("[TB] simultaneous done");
      applyStimulus(1'b1, 3'd5, 8'd30, 4'b0000);
      applyStimulus(1'b1, 3'd7, 8'd31, 4'b0000);
      applyStimulus(1'b1, 3'd6, 8'd32, 4'b0000);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b0101);
      checkOutput("t5_bank_done", 32'(bank_done), 32'h60);
      checkOutput("t5_slot_busy", 32'(slot_busy), 32'h2);
      applyStimulus(1'b1, 3'd0, 8'd3, 4'b0010);
      checkOutput("t5_acc_start", 32'(cnt_start), 32'h1);
      checkOutput("t5_acc_done", 32'(bank_done), 32'h80);

      $display("[TB] spurious done");
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b1000);
      checkOutput("t6_err", 32'(err_spurious), 32'd1);
      checkOutput("t6_slot_busy", 32'(slot_busy), 32'h1);
      applyStimulus(1'b0, 3'd0, 8'd0, 4'b0000);
      checkOutput("t6_sticky", 32'(err_spurious), 32'd1);
      doReset("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
